// File: rtl/register_file.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : register_file                                              |
// | Description : Architectural register file with per-register rename tags.|
// |               Issue returns operand values or producer ROB tags and     |
// |               renames rd; commit writes retired values and clears the   |
// |               tag when it still names the committing ROB entry; flush   |
// |               discards every tag.                                       |
// |               Optional macro RF_BYPASS_EN forwards a same-cycle commit  |
// |               to the read ports.                                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module register_file #(
   parameter int XLEN           = 32,
   parameter int REG_CNT_WIDTH  = 5,
   parameter int ROB_SIZE_WIDTH = 4,
   parameter int DEP_WIDTH      = ROB_SIZE_WIDTH + 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      stall,
   input  logic                      dec_ready,
   input  logic                      dec_writes_rd,
   input  logic [REG_CNT_WIDTH-1:0]  dec_rd,
   input  logic [REG_CNT_WIDTH-1:0]  dec_rs1,
   input  logic [REG_CNT_WIDTH-1:0]  dec_rs2,
   input  logic [ROB_SIZE_WIDTH-1:0] rob_tail_id,
   input  logic                      rob_write_enable,
   input  logic [REG_CNT_WIDTH-1:0]  rob_write_rd,
   input  logic [XLEN-1:0]           rob_write_val,
   input  logic [ROB_SIZE_WIDTH-1:0] rob_write_id,
   output logic [XLEN-1:0]           rf_val1,
   output logic [DEP_WIDTH-1:0]      rf_dep1,
   output logic [XLEN-1:0]           rf_val2,
   output logic [DEP_WIDTH-1:0]      rf_dep2
);

   localparam int                   c_REG_CNT  = 1 << REG_CNT_WIDTH;
   localparam logic [DEP_WIDTH-1:0] c_DEP_NONE = '1;

   logic [XLEN-1:0]      r_val [c_REG_CNT];
   logic [DEP_WIDTH-1:0] r_dep [c_REG_CNT];

   logic                 w_issue;
   logic                 w_commit;
   logic [DEP_WIDTH-1:0] w_issue_tag;
   logic [DEP_WIDTH-1:0] w_commit_tag;
   logic                 w_byp1;
   logic                 w_byp2;

   // x0 is excluded from both rename and commit so it never leaves its reset state
   assign w_issue      = dec_ready && dec_writes_rd && !stall && !flush && (dec_rd != '0);
   assign w_commit     = rob_write_enable && (rob_write_rd != '0);
   assign w_issue_tag  = {1'b0, rob_tail_id};
   assign w_commit_tag = {1'b0, rob_write_id};

`ifdef RF_BYPASS_EN
   // A source whose producer is retiring this cycle takes the retired value directly
   assign w_byp1 = rob_write_enable && (rob_write_rd == dec_rs1) && (dec_rs1 != '0) &&
                   (r_dep[dec_rs1] == w_commit_tag);
   assign w_byp2 = rob_write_enable && (rob_write_rd == dec_rs2) && (dec_rs2 != '0) &&
                   (r_dep[dec_rs2] == w_commit_tag);
`else
   // Reads see stored state only; the consumer picks up the value from the ROB
   assign w_byp1 = 1'b0;
   assign w_byp2 = 1'b0;
`endif

   // Register state: value written on commit, tag priority flush > issue > commit clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < c_REG_CNT; i++) begin
            r_val[i] <= '0;
            r_dep[i] <= c_DEP_NONE;
         end
      end else begin
         if (w_commit) begin
            r_val[rob_write_rd] <= rob_write_val;
         end
         for (int i = 1; i < c_REG_CNT; i++) begin
            if (flush) begin
               r_dep[i] <= c_DEP_NONE;
            end else if (w_issue && (dec_rd == REG_CNT_WIDTH'(i))) begin
               r_dep[i] <= w_issue_tag;
            end else if (w_commit && (rob_write_rd == REG_CNT_WIDTH'(i)) &&
                         (r_dep[i] == w_commit_tag)) begin
               // Only clear if no younger producer has renamed the register since
               r_dep[i] <= c_DEP_NONE;
            end
         end
      end
   end

   // Read port 1: pre-edge state, x0 hard-wired, optional commit forwarding
   always_comb begin
      rf_val1 = r_val[dec_rs1];
      rf_dep1 = r_dep[dec_rs1];
      if (dec_rs1 == '0) begin
         rf_val1 = '0;
         rf_dep1 = c_DEP_NONE;
      end else if (w_byp1) begin
         rf_val1 = rob_write_val;
         rf_dep1 = c_DEP_NONE;
      end
   end

   // Read port 2: pre-edge state, x0 hard-wired, optional commit forwarding
   always_comb begin
      rf_val2 = r_val[dec_rs2];
      rf_dep2 = r_dep[dec_rs2];
      if (dec_rs2 == '0) begin
         rf_val2 = '0;
         rf_dep2 = c_DEP_NONE;
      end else if (w_byp2) begin
         rf_val2 = rob_write_val;
         rf_dep2 = c_DEP_NONE;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_register_file                                           |
// | Description : Directed self-checking bench for register_file.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_register_file;

   localparam int XLEN = 32;
   localparam int RW   = 5;
   localparam int IW   = 4;
   localparam int DW   = 5;
   localparam logic [31:0] c_NONE = 32'h1F;

   logic            clk;
   logic            rst_n;
   logic            flush;
   logic            stall;
   logic            dec_ready;
   logic            dec_writes_rd;
   logic [RW-1:0]   dec_rd;
   logic [RW-1:0]   dec_rs1;
   logic [RW-1:0]   dec_rs2;
   logic [IW-1:0]   rob_tail_id;
   logic            rob_write_enable;
   logic [RW-1:0]   rob_write_rd;
   logic [XLEN-1:0] rob_write_val;
   logic [IW-1:0]   rob_write_id;
   logic [XLEN-1:0] rf_val1;
   logic [DW-1:0]   rf_dep1;
   logic [XLEN-1:0] rf_val2;
   logic [DW-1:0]   rf_dep2;

   int n_checks = 0;
   int n_pass   = 0;

   register_file #(
      .XLEN(XLEN), .REG_CNT_WIDTH(RW), .ROB_SIZE_WIDTH(IW), .DEP_WIDTH(DW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
      .dec_ready(dec_ready), .dec_writes_rd(dec_writes_rd), .dec_rd(dec_rd),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .rob_tail_id(rob_tail_id),
      .rob_write_enable(rob_write_enable), .rob_write_rd(rob_write_rd),
      .rob_write_val(rob_write_val), .rob_write_id(rob_write_id),
      .rf_val1(rf_val1), .rf_dep1(rf_dep1), .rf_val2(rf_val2), .rf_dep2(rf_dep2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("%s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs are then changed 1 ns after posedge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 0; stall = 0; dec_ready = 0; dec_writes_rd = 0; dec_rd = 0;
      rob_tail_id = 0; rob_write_enable = 0; rob_write_rd = 0;
      rob_write_val = 0; rob_write_id = 0;
   endtask

   task automatic issue(input logic [RW-1:0] rd, input logic [IW-1:0] id);
      dec_ready = 1; dec_writes_rd = 1; dec_rd = rd; rob_tail_id = id;
   endtask

   task automatic commit(input logic [RW-1:0] rd, input logic [IW-1:0] id,
                         input logic [XLEN-1:0] v);
      rob_write_enable = 1; rob_write_rd = rd; rob_write_id = id; rob_write_val = v;
   endtask

   initial begin
      idle();
      dec_rs1 = 5; dec_rs2 = 6;
      rst_n = 0;
      tick(); tick();
      // Reset state on both ports
      chk("rst_val1", rf_val1, 32'h0);
      chk("rst_dep1", 32'(rf_dep1), c_NONE);
      chk("rst_val2", rf_val2, 32'h0);
      chk("rst_dep2", 32'(rf_dep2), c_NONE);
      rst_n = 1;
      tick();

      // x0 ignores commits
      commit(0, 0, 32'hDEADBEEF);
      tick(); idle();
      dec_rs1 = 0; #1;
      chk("x0_val", rf_val1, 32'h0);
      chk("x0_dep", 32'(rf_dep1), c_NONE);

      // Rename then commit x3
      issue(3, 2);
      tick(); idle();
      dec_rs1 = 3; #1;
      chk("x3_dep_renamed", 32'(rf_dep1), 32'h2);
      commit(3, 2, 32'h1234);
      tick(); idle(); #1;
      chk("x3_val_commit", rf_val1, 32'h1234);
      chk("x3_dep_cleared", 32'(rf_dep1), c_NONE);

      // Older commit must not clear a younger tag
      issue(3, 2); tick();
      issue(3, 5); tick(); idle();
      commit(3, 2, 32'h7); tick(); idle(); #1;
      chk("x3_val_old", rf_val1, 32'h7);
      chk("x3_dep_young", 32'(rf_dep1), 32'h5);
      commit(3, 5, 32'h9); tick(); idle(); #1;
      chk("x3_val_young", rf_val1, 32'h9);
      chk("x3_dep_none", 32'(rf_dep1), c_NONE);

      // Same-edge issue and commit on x4: issue wins the tag
      issue(4, 1); tick(); idle();
      dec_rs1 = 4;
      issue(4, 6); commit(4, 1, 32'hAA); #1;
`ifdef RF_BYPASS_EN
      chk("x4_self_read", 32'(rf_dep1), c_NONE);
`else
      chk("x4_self_read", 32'(rf_dep1), 32'h1);
`endif
      tick(); idle(); #1;
      chk("x4_val_same", rf_val1, 32'hAA);
      chk("x4_dep_issue", 32'(rf_dep1), 32'h6);
      // Same again with stall: clear takes effect, rename does not
      issue(4, 1); tick(); idle();
      stall = 1; issue(4, 6); commit(4, 1, 32'hBB);
      tick(); idle(); #1;
      chk("x4_val_stall", rf_val1, 32'hBB);
      chk("x4_dep_stall", 32'(rf_dep1), c_NONE);

      // Flush clears every tag, keeps values, drops concurrent issue
      commit(1, 15, 32'h11); tick(); idle();
      issue(1, 7); tick();
      issue(2, 8); tick();
      issue(7, 9); tick(); idle();
      dec_rs1 = 1; dec_rs2 = 7; #1;
      chk("x1_dep_pre", 32'(rf_dep1), 32'h7);
      chk("x7_dep_pre", 32'(rf_dep2), 32'h9);
      flush = 1; issue(8, 10);
      tick(); idle(); #1;
      chk("x1_dep_flush", 32'(rf_dep1), c_NONE);
      chk("x1_val_flush", rf_val1, 32'h11);
      chk("x7_dep_flush", 32'(rf_dep2), c_NONE);
      dec_rs1 = 2; dec_rs2 = 8; #1;
      chk("x2_dep_flush", 32'(rf_dep1), c_NONE);
      chk("x8_no_rename", 32'(rf_dep2), c_NONE);
      dec_rs1 = 3; #1;
      chk("x3_val_kept", rf_val1, 32'h9);

      // Stalled issue does nothing
      stall = 1; issue(10, 4); tick(); idle();
      dec_rs1 = 10; #1;
      chk("x10_stall", 32'(rf_dep1), c_NONE);

      // Commit read-through on port 2
      issue(9, 3); tick(); idle();
      dec_rs2 = 9;
      commit(9, 3, 32'h55); #1;
`ifdef RF_BYPASS_EN
      chk("byp_dep2", 32'(rf_dep2), c_NONE);
      chk("byp_val2", rf_val2, 32'h55);
`else
      chk("byp_dep2", 32'(rf_dep2), 32'h3);
      chk("byp_val2", rf_val2, 32'h0);
`endif
      tick(); idle(); #1;
      chk("post_dep2", 32'(rf_dep2), c_NONE);
      chk("post_val2", rf_val2, 32'h55);

      // Asynchronous reset mid-operation clears state at once, dropping pending issue
      issue(3, 12); commit(9, 0, 32'h66);
      #1; rst_n = 0; #1;
      dec_rs1 = 3; #1;
      chk("arst_val3", rf_val1, 32'h0);
      chk("arst_val9", rf_val2, 32'h0);
      tick(); idle(); rst_n = 1; tick(); #1;
      chk("arst_dep3", 32'(rf_dep1), c_NONE);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
